// File: rtl/i2c_txn_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_txn_scheduler_pkg
//  Purpose  : Shared types for the I2C transaction scheduler.
//  Revision : 1.0
// ============================================================================
package i2c_txn_scheduler_pkg;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [2:0] {
        CMD_START    = 3'd0,
        CMD_STOP     = 3'd1,
        CMD_WRITE    = 3'd2,
        CMD_READ_ACK = 3'd3,
        CMD_READ_NAK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_ADDR  = 3'd3,
        ST_WDATA = 3'd4,
        ST_RDATA = 3'd5,
        ST_STOP  = 3'd6,
        ST_DONE  = 3'd7
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first request at/after ptr.
//  Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_txn_scheduler
//  Purpose  : Round-robin sharing of one byte-level I2C master engine.
//  Revision : 1.0
// ============================================================================
module i2c_txn_scheduler
    import i2c_txn_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]                  req_op_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]        req_len_i,
    input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0]   wr_data_i,
    input  logic [NUM_REQ-1:0]                  wr_valid_i,
    output logic [NUM_REQ-1:0]                  wr_ready_o,
    output logic [I2C_DATA_WIDTH-1:0]           rd_data_o,
    output logic [NUM_REQ-1:0]                  rd_valid_o,
    output logic [NUM_REQ-1:0]                  done_o,
    output logic                                nak_o,
    output logic                                cmd_valid_o,
    input  logic                                cmd_ready_i,
    output logic [2:0]                          cmd_o,
    output logic [I2C_DATA_WIDTH-1:0]           cmd_data_o,
    input  logic                                rsp_valid_i,
    input  logic                                rsp_nak_i,
    input  logic [I2C_DATA_WIDTH-1:0]           rsp_data_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);

    sched_state_t               r_state;
    sched_state_t               w_next;
    logic [PTR_W-1:0]           r_ptr;
    logic [PTR_W-1:0]           r_gidx;
    logic [I2C_ADDR_WIDTH-1:0]  r_addr;
    i2c_op_t                    r_op;
    logic [LEN_WIDTH-1:0]       r_len;
    logic                       r_err;
    logic                       r_pending;
    logic [I2C_DATA_WIDTH-1:0]  r_rd_data;
    logic [NUM_REQ-1:0]         r_rd_valid;

    logic [NUM_REQ-1:0]         w_arb_grant;
    logic                       w_arb_valid;
    logic [PTR_W-1:0]           w_arb_idx;
    logic                       w_rsp;
    logic                       w_fire;
    logic [I2C_DATA_WIDTH-1:0]  w_addr_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (req_valid_i),
        .ptr   (r_ptr),
        .grant (w_arb_grant),
        .valid (w_arb_valid)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) begin
                w_arb_idx = PTR_W'(i);
            end
        end
    end

    // A response only counts when a command is actually outstanding.
    assign w_rsp       = r_pending && rsp_valid_i;
    assign w_fire      = cmd_valid_o && cmd_ready_i;
    assign w_addr_byte = I2C_DATA_WIDTH'({r_addr, r_op});
    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_arb_valid) w_next = ST_GRANT;
            ST_GRANT: w_next = ST_START;
            ST_START: if (w_rsp) w_next = ST_ADDR;
            ST_ADDR: begin
                if (w_rsp) begin
                    if (rsp_nak_i || (r_len == '0)) w_next = ST_STOP;
                    else if (r_op == I2C_WRITE)     w_next = ST_WDATA;
                    else                            w_next = ST_RDATA;
                end
            end
            ST_WDATA: if (w_rsp && (rsp_nak_i || (r_len == c_len_one))) w_next = ST_STOP;
            ST_RDATA: if (w_rsp && (r_len == c_len_one)) w_next = ST_STOP;
            ST_STOP:  if (w_rsp) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_addr     <= '0;
            r_op       <= I2C_WRITE;
            r_len      <= '0;
            r_err      <= 1'b0;
            r_pending  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= '0;
            if (w_fire) begin
                r_pending <= 1'b1;
            end else if (rsp_valid_i) begin
                r_pending <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) r_gidx <= w_arb_idx;
                end
                ST_GRANT: begin
                    r_addr <= req_addr_i[r_gidx*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
                    r_op   <= i2c_op_t'(req_op_i[r_gidx]);
                    r_len  <= req_len_i[r_gidx*LEN_WIDTH +: LEN_WIDTH];
                end
                ST_ADDR: begin
                    if (w_rsp && rsp_nak_i) r_err <= 1'b1;
                end
                ST_WDATA: begin
                    if (w_rsp) begin
                        r_len <= r_len - c_len_one;
                        if (rsp_nak_i) r_err <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (w_rsp) begin
                        r_len              <= r_len - c_len_one;
                        r_rd_data          <= rsp_data_i;
                        r_rd_valid[r_gidx] <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_ptr <= (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        wr_ready_o  = '0;
        done_o      = '0;
        nak_o       = 1'b0;
        cmd_valid_o = 1'b0;
        cmd_o       = CMD_START;
        cmd_data_o  = '0;
        case (r_state)
            ST_GRANT: req_ready_o[r_gidx] = 1'b1;
            ST_START: begin
                cmd_valid_o = !r_pending;
                cmd_o       = CMD_START;
            end
            ST_ADDR: begin
                cmd_valid_o = !r_pending;
                cmd_o       = CMD_WRITE;
                cmd_data_o  = w_addr_byte;
            end
            ST_WDATA: begin
                // The byte is only offered once the requester has one ready.
                cmd_valid_o        = !r_pending && wr_valid_i[r_gidx];
                cmd_o              = CMD_WRITE;
                cmd_data_o         = wr_data_i[r_gidx*I2C_DATA_WIDTH +: I2C_DATA_WIDTH];
                wr_ready_o[r_gidx] = !r_pending && wr_valid_i[r_gidx] && cmd_ready_i;
            end
            ST_RDATA: begin
                cmd_valid_o = !r_pending;
                cmd_o       = (r_len == c_len_one) ? CMD_READ_NAK : CMD_READ_ACK;
            end
            ST_STOP: begin
                cmd_valid_o = !r_pending;
                cmd_o       = CMD_STOP;
            end
            ST_DONE: begin
                done_o[r_gidx] = 1'b1;
                nak_o          = r_err;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_txn_scheduler
//  Purpose  : Directed, table-driven bench with a simple engine/requester model.
//  Revision : 1.0
// ============================================================================
module tb_i2c_txn_scheduler;
    import i2c_txn_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i, req_ready_o, req_op_i, wr_valid_i, wr_ready_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*LW-1:0] req_len_i;
    logic [N*DW-1:0] wr_data_i;
    logic [DW-1:0]   rd_data_o, cmd_data_o, rsp_data_i;
    logic [N-1:0]    rd_valid_o, done_o;
    logic            nak_o, cmd_valid_o, cmd_ready_i, rsp_valid_i, rsp_nak_i;
    logic [2:0]      cmd_o;

    always #5 clk = ~clk;

    i2c_txn_scheduler #(
        .NUM_REQ(N), .I2C_ADDR_WIDTH(AW), .I2C_DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_len_i(req_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .done_o(done_o), .nak_o(nak_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_o(cmd_o), .cmd_data_o(cmd_data_o),
        .rsp_valid_i(rsp_valid_i), .rsp_nak_i(rsp_nak_i), .rsp_data_i(rsp_data_i)
    );

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] data;
    } cmd_rec_t;

    typedef struct {
        int         req;
        logic [6:0] addr;
        logic       op;
        int         len;
        int         nak_at;
        logic [7:0] abyte;
        int         ncmds;
        int         nwr;
        int         nrd;
        logic       nak;
    } vec_t;

    cmd_rec_t   cmd_log[$];
    logic [3:0] grant_log[$];
    logic [4:0] done_log[$];
    logic [11:0] rd_log[$];

    int         stall_cycles = 0;
    int         stall_cnt    = 0;
    int         stall_bad    = 0;
    int         stall_seen   = 0;
    int         nak_abs      = -1;
    bit         busy         = 1'b0;
    logic       pend_nak     = 1'b0;
    logic [7:0] pend_data    = 8'h00;
    logic [7:0] rd_seq       = 8'h00;
    cmd_rec_t   stall_ref;
    logic [N-1:0] hs_wr      = '0;
    int         wr_idx[N]    = '{0, 0, 0, 0};
    int         wr_pulses[N] = '{0, 0, 0, 0};

    int checks   = 0;
    int failures = 0;
    int g_proc   = 0;

    // Each requester offers bytes 0x11, 0x33, 0x55, ... in order.
    always_comb begin
        wr_data_i = '0;
        for (int r = 0; r < N; r++) begin
            wr_data_i[r*DW +: DW] = 8'(8'h11 + wr_idx[r] * 34);
        end
    end

    // Engine model and output monitor: acts just after each falling edge.
    always @(negedge clk) begin
        #1;
        for (int r = 0; r < N; r++) begin
            if (hs_wr[r]) begin
                wr_idx[r]    = wr_idx[r] + 1;
                wr_pulses[r] = wr_pulses[r] + 1;
            end
        end
        hs_wr       = '0;
        rsp_valid_i = 1'b0;
        rsp_nak_i   = 1'b0;
        rsp_data_i  = 8'h00;
        cmd_ready_i = 1'b0;
        if (rst_i) begin
            busy      = 1'b0;
            stall_cnt = 0;
        end else begin
            if (req_ready_o != '0) grant_log.push_back(req_ready_o);
            if (done_o != '0)      done_log.push_back({nak_o, done_o});
            if (rd_valid_o != '0)  rd_log.push_back({rd_valid_o, rd_data_o});
            if (busy) begin
                rsp_valid_i = 1'b1;
                rsp_nak_i   = pend_nak;
                rsp_data_i  = pend_data;
                busy        = 1'b0;
            end else if (cmd_valid_o) begin
                if (stall_cnt == 0) begin
                    stall_ref.cmd  = cmd_o;
                    stall_ref.data = cmd_data_o;
                end else if (cmd_o !== stall_ref.cmd || cmd_data_o !== stall_ref.data) begin
                    stall_bad = stall_bad + 1;
                end
                if (stall_cnt >= stall_cycles) begin
                    cmd_ready_i = 1'b1;
                    stall_cnt   = 0;
                    cmd_log.push_back('{cmd: cmd_o, data: cmd_data_o});
                    pend_nak  = ((cmd_log.size() - 1) == nak_abs);
                    pend_data = 8'h00;
                    if (cmd_o == CMD_START) rd_seq = 8'h00;
                    if (cmd_o == CMD_READ_ACK || cmd_o == CMD_READ_NAK) begin
                        pend_data = 8'hA0 + rd_seq;
                        rd_seq    = rd_seq + 8'h01;
                    end
                    busy = 1'b1;
                    #1;
                    hs_wr = wr_ready_o;
                end else begin
                    stall_cnt  = stall_cnt + 1;
                    stall_seen = stall_seen + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle; a granted requester drops its request straight away.
    task automatic step();
        @(posedge clk);
        #2;
        while (g_proc < grant_log.size()) begin
            req_valid_i = req_valid_i & ~grant_log[g_proc];
            g_proc = g_proc + 1;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int c = 0;
        while (done_log.size() < target && c < budget) begin
            step();
            c++;
        end
        chk(name, done_log.size(), target);
    endtask

    task automatic drive_req(input int r, input logic [6:0] a, input logic op, input int len);
        req_addr_i[r*AW +: AW] = a;
        req_op_i[r]            = op;
        req_len_i[r*LW +: LW]  = LW'(len);
        wr_valid_i[r]          = (op == 1'b0);
        req_valid_i[r]         = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_valid"}, cmd_valid_o, 0);
        chk({tag, "_req_ready"}, req_ready_o, 0);
        chk({tag, "_wr_ready"},  wr_ready_o, 0);
        chk({tag, "_rd_valid"},  rd_valid_o, 0);
        chk({tag, "_done"},      done_o, 0);
        chk({tag, "_nak"},       nak_o, 0);
        chk({tag, "_rd_data"},   rd_data_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cb = cmd_log.size();
        int rb = rd_log.size();
        int db = done_log.size();
        int gb = grant_log.size();
        int wp = wr_pulses[v.req];
        int wi = wr_idx[v.req];
        int ndata;
        logic [2:0] exp_cmd;
        nak_abs = (v.nak_at < 0) ? -1 : cb + v.nak_at;
        drive_req(v.req, v.addr, v.op, v.len);
        wait_done(db + 1, 400, {tag, "_complete"});
        wr_valid_i[v.req] = 1'b0;
        nak_abs = -1;
        if (grant_log.size() > gb) chk({tag, "_grant"}, grant_log[gb], 32'(1 << v.req));
        chk({tag, "_ncmds"}, cmd_log.size() - cb, v.ncmds);
        if (cmd_log.size() >= cb + v.ncmds && v.ncmds >= 3) begin
            chk({tag, "_start"}, cmd_log[cb].cmd, CMD_START);
            chk({tag, "_addr"}, {cmd_log[cb+1].cmd, cmd_log[cb+1].data}, {CMD_WRITE, v.abyte});
            chk({tag, "_stop"}, cmd_log[cb+v.ncmds-1].cmd, CMD_STOP);
            ndata = v.ncmds - 3;
            for (int k = 0; k < ndata; k++) begin
                if (v.op == 1'b0) begin
                    chk($sformatf("%s_wbyte%0d", tag, k),
                        {cmd_log[cb+2+k].cmd, cmd_log[cb+2+k].data},
                        {CMD_WRITE, 8'(8'h11 + (wi + k) * 34)});
                end else begin
                    exp_cmd = (k == v.len - 1) ? CMD_READ_NAK : CMD_READ_ACK;
                    chk($sformatf("%s_rcmd%0d", tag, k), cmd_log[cb+2+k].cmd, exp_cmd);
                end
            end
        end
        chk({tag, "_wr_pulses"}, wr_pulses[v.req] - wp, v.nwr);
        chk({tag, "_rd_count"}, rd_log.size() - rb, v.nrd);
        for (int k = 0; k < v.nrd; k++) begin
            if (rb + k < rd_log.size())
                chk($sformatf("%s_rd%0d", tag, k), rd_log[rb+k], {4'(1 << v.req), 8'(8'hA0 + k)});
        end
        if (done_log.size() > db) chk({tag, "_done"}, done_log[db], {v.nak, 4'(1 << v.req)});
    endtask

    vec_t vecs[6];

    initial begin
        int gb, cb, wp, db;
        vecs[0] = '{0, 7'h22, 1'b0, 2, -1, 8'h44, 5, 2, 0, 1'b0};
        vecs[1] = '{1, 7'h50, 1'b0, 4,  1, 8'hA0, 3, 0, 0, 1'b1};
        vecs[2] = '{3, 7'h7F, 1'b0, 3,  3, 8'hFE, 5, 2, 0, 1'b1};
        vecs[3] = '{1, 7'h10, 1'b1, 0, -1, 8'h21, 3, 0, 0, 1'b0};
        vecs[4] = '{0, 7'h01, 1'b1, 1, -1, 8'h03, 4, 0, 1, 1'b0};
        vecs[5] = '{2, 7'h22, 1'b1, 3, -1, 8'h45, 6, 0, 3, 1'b0};

        rst_i       = 1'b1;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_op_i    = '0;
        req_len_i   = '0;
        wr_valid_i  = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // len=0 with every command stalled for five cycles.
        stall_cycles = 5;
        wp = stall_bad;
        db = stall_seen;
        run_vec('{1, 7'h3C, 1'b0, 0, -1, 8'h78, 3, 0, 0, 1'b0}, "stall");
        stall_cycles = 0;
        chk("stall_cmd_stable", stall_bad - wp, 0);
        chk("stall_cycles", stall_seen - db, 15);
        step();

        // Reset in the middle of a write, then a fresh arbitration.
        wp = wr_pulses[0];
        drive_req(0, 7'h33, 1'b0, 3);
        begin
            int c = 0;
            while (wr_pulses[0] == wp && c < 200) begin
                step();
                c++;
            end
        end
        chk("rst_reached_wdata", wr_pulses[0] - wp, 1);
        rst_i       = 1'b1;
        req_valid_i = '0;
        wr_valid_i  = '0;
        step();
        check_idle_outputs("midrst");
        rst_i = 1'b0;
        step();
        gb = grant_log.size();
        cb = cmd_log.size();
        db = done_log.size();
        drive_req(1, 7'h11, 1'b0, 1);
        drive_req(3, 7'h12, 1'b0, 1);
        wait_done(db + 2, 400, "postrst_complete");
        wr_valid_i = '0;
        if (grant_log.size() >= gb + 2) begin
            chk("postrst_grant0", grant_log[gb], 4'b0010);
            chk("postrst_grant1", grant_log[gb+1], 4'b1000);
        end
        if (cmd_log.size() > cb) chk("postrst_first_cmd", cmd_log[cb].cmd, CMD_START);
        step();

        // Round-robin with all four requesting together.
        gb = grant_log.size();
        db = done_log.size();
        for (int r = 0; r < N; r++) drive_req(r, 7'(7'h40 + r), 1'b0, 1);
        wait_done(db + 4, 800, "rr_complete");
        wr_valid_i = '0;
        for (int k = 0; k < 4; k++) begin
            if (gb + k < grant_log.size())
                chk($sformatf("rr_grant%0d", k), grant_log[gb+k], 32'(1 << k));
        end
        step();
        gb = grant_log.size();
        db = done_log.size();
        drive_req(0, 7'h40, 1'b0, 1);
        drive_req(3, 7'h43, 1'b0, 1);
        wait_done(db + 2, 400, "rr2_complete");
        wr_valid_i = '0;
        if (grant_log.size() >= gb + 2) begin
            chk("rr2_grant0", grant_log[gb], 4'b0001);
            chk("rr2_grant1", grant_log[gb+1], 4'b1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
